// File: rtl/rf_cmd_ctrl_pkg.sv
// rtl/rf_cmd_ctrl_pkg.sv - shared opcodes, FSM encoding and size defaults for rf_cmd_ctrl
//
// Contents:
//   WIDTH_DEF / NREG_DEF / AW_DEF : default register width, count and address width
//   op_e                          : command opcodes (LOAD, COPY, SWAP, READ)
//   state_e                       : controller states (IDLE, RD, WR1, WR2)
package rf_cmd_ctrl_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREG_DEF  = 8;
    localparam int AW_DEF    = 3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_COPY = 2'd1,
        OP_SWAP = 2'd2,
        OP_READ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR1  = 2'd2,
        ST_WR2  = 2'd3
    } state_e;

endpackage

// File: rtl/rf_cmd_ctrl_onehot_dec.sv
// rtl/rf_cmd_ctrl_onehot_dec.sv - AW-to-NREG one-hot decoder with enable
//
// Ports:
//   i_en     : when 0 the output is all zeros
//   i_idx    : binary index to decode
//   o_onehot : one-hot vector, bit i_idx set when enabled
module onehot_dec #(
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic            i_en,
    input  logic [AW-1:0]   i_idx,
    output logic [NREG-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_en && (i_idx == AW'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_cmd_ctrl.sv
// rtl/rf_cmd_ctrl.sv - command sequencer driving a register file (LOAD/COPY/SWAP/READ)
//
// Ports:
//   clk, reset           : clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake, accepted when both high at a rising edge
//   cmd_op/src/dst/data  : opcode, source index, destination index, LOAD immediate
//   ld, Din              : one-hot register write enable and write data
//   oeA, oeB             : one-hot read enables for register-file buses A and B
//   DA, DB               : register-file read buses A and B
//   done                 : one-cycle pulse in the final execute cycle of a command
//   rsp_a, rsp_b         : READ results, valid while done is high for READ, held otherwise
module rf_cmd_ctrl
    import rf_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [NREG-1:0]  ld,
    output logic [WIDTH-1:0] Din,
    output logic [NREG-1:0]  oeA,
    output logic [NREG-1:0]  oeB,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    output logic             done,
    output logic [WIDTH-1:0] rsp_a,
    output logic [WIDTH-1:0] rsp_b
);

    state_e           r_state;
    state_e           w_next;
    op_e              r_op;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_tmp_a;
    logic [WIDTH-1:0] r_tmp_b;
    logic [WIDTH-1:0] r_rsp_a;
    logic [WIDTH-1:0] r_rsp_b;

    logic             w_accept;
    logic             w_ld_en;
    logic [AW-1:0]    w_ld_idx;
    logic             w_oea_en;
    logic             w_oeb_en;
    logic             w_read_now;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_read_now = (r_state == ST_RD) && (r_op == OP_READ);

    // Command fields are only sampled on acceptance, so cmd_* activity while
    // busy cannot disturb the command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_tmp_a <= '0;
            r_tmp_b <= '0;
            r_rsp_a <= '0;
            r_rsp_b <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op_e'(cmd_op);
                r_src  <= cmd_src;
                r_dst  <= cmd_dst;
                r_data <= cmd_data;
            end
            if (r_state == ST_RD) begin
                r_tmp_a <= DA;
                if (r_op == OP_SWAP) begin
                    r_tmp_b <= DB;
                end
            end
            if (w_read_now) begin
                r_rsp_a <= DA;
                r_rsp_b <= DB;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        w_ld_en   = 1'b0;
        w_ld_idx  = r_dst;
        w_oea_en  = 1'b0;
        w_oeb_en  = 1'b0;
        Din       = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = (op_e'(cmd_op) == OP_LOAD) ? ST_WR1 : ST_RD;
                end
            end
            ST_RD: begin
                w_oea_en = 1'b1;
                // COPY only needs the source on bus A.
                w_oeb_en = (r_op != OP_COPY);
                if (r_op == OP_READ) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WR1;
                end
            end
            ST_WR1: begin
                w_ld_en  = 1'b1;
                w_ld_idx = r_dst;
                Din      = (r_op == OP_LOAD) ? r_data : r_tmp_a;
                if (r_op == OP_SWAP) begin
                    w_next = ST_WR2;
                end else begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WR2: begin
                w_ld_en  = 1'b1;
                w_ld_idx = r_src;
                Din      = r_tmp_b;
                done     = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // READ results are passed straight through during the done cycle and
    // held in the response registers afterwards.
    assign rsp_a = w_read_now ? DA : r_rsp_a;
    assign rsp_b = w_read_now ? DB : r_rsp_b;

    onehot_dec #(.AW(AW), .NREG(NREG)) u_ld_dec (
        .i_en     (w_ld_en),
        .i_idx    (w_ld_idx),
        .o_onehot (ld)
    );

    onehot_dec #(.AW(AW), .NREG(NREG)) u_oea_dec (
        .i_en     (w_oea_en),
        .i_idx    (r_src),
        .o_onehot (oeA)
    );

    onehot_dec #(.AW(AW), .NREG(NREG)) u_oeb_dec (
        .i_en     (w_oeb_en),
        .i_idx    (r_dst),
        .o_onehot (oeB)
    );

endmodule
